// File: rtl/arb_resp_demux_pkg.sv
// arb_resp_demux_pkg: shared width helpers and default type aliases for the
// arbitrated request / in-order response demux.
package arb_resp_demux_pkg;

  // Width of an outstanding counter able to hold 0..max_trans.
  function automatic int unsigned cnt_width(input int unsigned max_trans);
    return $clog2(max_trans + 1);
  endfunction

  // Pointer width; a single-entry queue still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned max_trans);
    return (max_trans > 1) ? $clog2(max_trans) : 1;
  endfunction

  localparam int unsigned DefNumIn    = 4;
  localparam int unsigned DefMaxTrans = 4;

  typedef logic [$clog2(DefNumIn)-1:0]       idx_t;
  typedef logic [cnt_width(DefMaxTrans)-1:0] cnt_t;

endpackage

// File: rtl/arb_resp_idx_queue.sv
// arb_resp_idx_queue: in-order FIFO of winning input indices with an
// occupancy counter. Pointers wrap modulo MaxTrans (any depth), flush wins
// over push/pop, push is ignored when full and pop when empty.
module arb_resp_idx_queue
  import arb_resp_demux_pkg::*;
#(
  parameter int unsigned MaxTrans = 4,
  parameter int unsigned IdxWidth = 2,
  parameter int unsigned CntWidth = cnt_width(MaxTrans)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [IdxWidth-1:0] idx_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [IdxWidth-1:0] head_o,
  output logic [CntWidth-1:0] count_o
);

  localparam int unsigned PtrW = ptr_width(MaxTrans);

  logic [MaxTrans-1:0][IdxWidth-1:0] mem_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntWidth'(MaxTrans));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop)      cnt_d = cnt_q + CntWidth'(1);
    else if (pop & ~push) cnt_d = cnt_q - CntWidth'(1);
  end

  // Pointer, counter and storage update; flush clears tracking state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= idx_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/arb_resp_demux.sv
// arb_resp_demux: forwards arbitrated requests to one slave, tracks the
// winning index in order and steers each slave response back to its master.
// Optional macro ARB_RESP_DEMUX_SPILL_EN adds a one-entry response register.
module arb_resp_demux
  import arb_resp_demux_pkg::*;
#(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned MaxTrans     = 4,
  parameter int unsigned ReqDataWidth = 32,
  parameter int unsigned RspDataWidth = 32,
  parameter int unsigned IdxWidth     = $clog2(NumIn)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [IdxWidth-1:0]             req_idx_i,
  input  logic [ReqDataWidth-1:0]         req_data_i,
  output logic                            slv_req_valid_o,
  input  logic                            slv_req_ready_i,
  output logic [ReqDataWidth-1:0]         slv_req_data_o,
  input  logic                            slv_rsp_valid_i,
  output logic                            slv_rsp_ready_o,
  input  logic [RspDataWidth-1:0]         slv_rsp_data_i,
  output logic [NumIn-1:0]                mst_rsp_valid_o,
  input  logic [NumIn-1:0]                mst_rsp_ready_i,
  output logic [RspDataWidth-1:0]         mst_rsp_data_o,
  output logic [$clog2(MaxTrans+1)-1:0]   outstanding_o
);

  localparam int unsigned CntW = cnt_width(MaxTrans);

  logic                q_full, q_empty, push, pop;
  logic [IdxWidth-1:0] head;
  logic [IdxWidth-1:0] sel_idx;
  logic                sel_vld;

  // Request path: zero latency, gated only by queue occupancy.
  assign slv_req_valid_o = req_valid_i & ~q_full;
  assign req_ready_o     = slv_req_ready_i & ~q_full;
  assign slv_req_data_o  = req_data_i;
  assign push            = req_valid_i & req_ready_o;
  assign pop             = slv_rsp_valid_i & slv_rsp_ready_o;

  arb_resp_idx_queue #(
    .MaxTrans (MaxTrans),
    .IdxWidth (IdxWidth),
    .CntWidth (CntW)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .idx_i   (req_idx_i),
    .pop_i   (pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head),
    .count_o (outstanding_o)
  );

`ifdef ARB_RESP_DEMUX_SPILL_EN
  logic                    spill_vld_q;
  logic [IdxWidth-1:0]     spill_idx_q;
  logic [RspDataWidth-1:0] spill_data_q;
  logic                    drain;

  assign drain           = spill_vld_q & mst_rsp_ready_i[spill_idx_q];
  assign slv_rsp_ready_o = ~q_empty & (~spill_vld_q | drain);
  assign sel_vld         = spill_vld_q;
  assign sel_idx         = spill_idx_q;
  assign mst_rsp_data_o  = spill_data_q;

  // Spill register: loads on accept, empties when its master takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spill_vld_q  <= 1'b0;
      spill_idx_q  <= '0;
      spill_data_q <= '0;
    end else if (flush_i) begin
      spill_vld_q  <= 1'b0;
    end else if (pop) begin
      spill_vld_q  <= 1'b1;
      spill_idx_q  <= head;
      spill_data_q <= slv_rsp_data_i;
    end else if (drain) begin
      spill_vld_q  <= 1'b0;
    end
  end
`else
  assign slv_rsp_ready_o = mst_rsp_ready_i[head] & ~q_empty;
  assign sel_vld         = slv_rsp_valid_i & ~q_empty;
  assign sel_idx         = head;
  assign mst_rsp_data_o  = slv_rsp_data_i;
`endif

  // Onehot decode of the selected index onto the per-master valids.
  for (genvar g = 0; g < NumIn; g++) begin : g_dec
    assign mst_rsp_valid_o[g] = sel_vld & (sel_idx == IdxWidth'(g));
  end

`ifndef SYNTHESIS
  logic                stall_q;
  logic [IdxWidth-1:0] stall_idx_q;

  // Remember a stalled request so its stability can be checked next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q     <= 1'b0;
      stall_idx_q <= '0;
    end else begin
      stall_q     <= req_valid_i & ~req_ready_o;
      stall_idx_q <= req_idx_i;
    end
  end

  // Protocol checks on the arbiter and slave interfaces.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(mst_rsp_valid_o)) else $error("mst_rsp_valid_o not onehot0");
      if (req_valid_i)
        assert (int'(req_idx_i) < int'(NumIn)) else $error("req_idx_i out of range");
      if (stall_q)
        assert (req_valid_i && req_idx_i == stall_idx_q)
          else $error("request changed before acceptance");
      if (slv_rsp_valid_i)
        assert (!q_empty) else $warning("slave response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_arb_resp_demux.sv
// tb_arb_resp_demux: directed bench for the default (combinational response)
// build with NumIn=4, MaxTrans=4.
module tb_arb_resp_demux;
  import arb_resp_demux_pkg::*;

  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic        req_valid_i = 1'b0, slv_req_ready_i = 1'b0, slv_rsp_valid_i = 1'b0;
  idx_t        req_idx_i = '0;
  logic [31:0] req_data_i = '0, slv_rsp_data_i = '0;
  logic [3:0]  mst_rsp_ready_i = '0;
  logic        req_ready_o, slv_req_valid_o, slv_rsp_ready_o;
  logic [31:0] slv_req_data_o, mst_rsp_data_o;
  logic [3:0]  mst_rsp_valid_o;
  cnt_t        outstanding_o;

  int n_vec = 0, n_err = 0;
  idx_t exp_q[$];

  arb_resp_demux #(.NumIn(4), .MaxTrans(4), .ReqDataWidth(32), .RspDataWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_idx_i(req_idx_i),
    .req_data_i(req_data_i), .slv_req_valid_o(slv_req_valid_o),
    .slv_req_ready_i(slv_req_ready_i), .slv_req_data_o(slv_req_data_o),
    .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_ready_o(slv_rsp_ready_o),
    .slv_rsp_data_i(slv_rsp_data_i), .mst_rsp_valid_o(mst_rsp_valid_o),
    .mst_rsp_ready_i(mst_rsp_ready_i), .mst_rsp_data_o(mst_rsp_data_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input idx_t idx);
    req_valid_i = 1'b1; req_idx_i = idx; req_data_i = 32'h100 + 32'(idx);
    slv_req_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_outstanding", 32'(outstanding_o), 0);
    chk("rst_req_ready", 32'(req_ready_o), 0);
    chk("rst_slv_req_valid", 32'(slv_req_valid_o), 0);
    chk("rst_slv_rsp_ready", 32'(slv_rsp_ready_o), 0);
    chk("rst_mst_valid", 32'(mst_rsp_valid_o), 0);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();

    // Single transaction: idx 2, response 0xA5 three cycles later
    req_valid_i = 1'b1; req_idx_i = 2; req_data_i = 32'h11; slv_req_ready_i = 1'b1;
    #1;
    chk("t1_req_ready", 32'(req_ready_o), 1);
    chk("t1_slv_req_valid", 32'(slv_req_valid_o), 1);
    chk("t1_slv_req_data", slv_req_data_o, 32'h11);
    tick();
    req_valid_i = 1'b0;
    chk("t1_outstanding_1", 32'(outstanding_o), 1);
    tick(); tick();
    slv_rsp_valid_i = 1'b1; slv_rsp_data_i = 32'hA5; mst_rsp_ready_i = 4'b0100;
    #1;
    chk("t1_mst_valid", 32'(mst_rsp_valid_o), 32'b0100);
    chk("t1_mst_data", mst_rsp_data_o, 32'hA5);
    chk("t1_slv_rsp_ready", 32'(slv_rsp_ready_o), 1);
    tick();
    slv_rsp_valid_i = 1'b0;
    chk("t1_outstanding_0", 32'(outstanding_o), 0);

    // Order tracking: 3,0,1 then in-order responses
    push_one(3); push_one(0); push_one(1);
    chk("t2_outstanding", 32'(outstanding_o), 3);
    exp_q = '{3, 0, 1};
    mst_rsp_ready_i = 4'b1111; slv_rsp_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      slv_rsp_data_i = 32'hD0 + 32'(k);
      #1;
      chk("t2_route", 32'(mst_rsp_valid_o), 32'(4'b0001 << exp_q[k]));
      chk("t2_data", mst_rsp_data_o, 32'hD0 + 32'(k));
      tick();
    end
    slv_rsp_valid_i = 1'b0;
    chk("t2_drained", 32'(outstanding_o), 0);

    // Full boundary, including pop and 5th request in the same cycle
    push_one(0); push_one(1); push_one(2); push_one(3);
    chk("t3_full_count", 32'(outstanding_o), 4);
    req_valid_i = 1'b1; req_idx_i = 2; req_data_i = 32'h55;
    #1;
    chk("t3_stall_ready", 32'(req_ready_o), 0);
    chk("t3_stall_valid", 32'(slv_req_valid_o), 0);
    tick();
    chk("t3_stall_ready2", 32'(req_ready_o), 0);
    slv_rsp_valid_i = 1'b1; mst_rsp_ready_i = 4'b1111;
    #1;
    chk("t3_pop_head", 32'(mst_rsp_valid_o), 32'b0001);
    chk("t3_same_cycle_ready", 32'(req_ready_o), 0);
    tick();
    slv_rsp_valid_i = 1'b0;
    chk("t3_after_pop_count", 32'(outstanding_o), 3);
    chk("t3_after_pop_ready", 32'(req_ready_o), 1);
    tick();
    req_valid_i = 1'b0;
    chk("t3_refull_count", 32'(outstanding_o), 4);
    exp_q = '{1, 2, 3, 2};
    slv_rsp_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_drain_route", 32'(mst_rsp_valid_o), 32'(4'b0001 << exp_q[k]));
      tick();
    end
    slv_rsp_valid_i = 1'b0;
    chk("t3_drained", 32'(outstanding_o), 0);

    // Simultaneous push/pop at count 2 for 10 cycles (pointers wrap)
    push_one(0); push_one(1);
    exp_q = '{0, 1};
    for (int k = 0; k < 10; k++) begin
      idx_t nidx;
      nidx = idx_t'((3 * k + 2) % 4);
      req_valid_i = 1'b1; req_idx_i = nidx; slv_req_ready_i = 1'b1;
      slv_rsp_valid_i = 1'b1; mst_rsp_ready_i = 4'b1111;
      #1;
      chk("t4_route", 32'(mst_rsp_valid_o), 32'(4'b0001 << exp_q[0]));
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(nidx);
      chk("t4_count", 32'(outstanding_o), 2);
    end
    req_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t4_drain_route", 32'(mst_rsp_valid_o), 32'(4'b0001 << exp_q[k]));
      tick();
    end
    slv_rsp_valid_i = 1'b0;
    chk("t4_drained", 32'(outstanding_o), 0);

    // Backpressure: head idx 1 not ready, others ready
    push_one(1); push_one(3);
    slv_rsp_valid_i = 1'b1; mst_rsp_ready_i = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_bp_ready", 32'(slv_rsp_ready_o), 0);
      chk("t5_bp_valid", 32'(mst_rsp_valid_o), 32'b0010);
      tick();
      chk("t5_bp_count", 32'(outstanding_o), 2);
    end
    mst_rsp_ready_i = 4'b0010;
    tick();
    chk("t5_pop1_count", 32'(outstanding_o), 1);
    mst_rsp_ready_i = 4'b1000;
    #1;
    chk("t5_head3", 32'(mst_rsp_valid_o), 32'b1000);
    tick();
    slv_rsp_valid_i = 1'b0;
    chk("t5_drained", 32'(outstanding_o), 0);

    // Flush with 3 outstanding
    push_one(0); push_one(1); push_one(2);
    chk("t6_pre_flush", 32'(outstanding_o), 3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t6_flushed", 32'(outstanding_o), 0);
    slv_rsp_valid_i = 1'b1; mst_rsp_ready_i = 4'b1111;
    #1;
    chk("t6_empty_ready", 32'(slv_rsp_ready_o), 0);
    chk("t6_empty_valid", 32'(mst_rsp_valid_o), 0);
    slv_rsp_valid_i = 1'b0;
    push_one(3);
    slv_rsp_valid_i = 1'b1;
    #1;
    chk("t6_post_flush_head", 32'(mst_rsp_valid_o), 32'b1000);
    tick();
    slv_rsp_valid_i = 1'b0;

    // Async reset mid-burst
    push_one(2); push_one(1);
    slv_rsp_valid_i = 1'b1; mst_rsp_ready_i = 4'b0000;
    #1;
    chk("t7_pre_rst_valid", 32'(mst_rsp_valid_o), 32'b0100);
    #1 rst_ni = 1'b0;
    #1;
    chk("t7_rst_count", 32'(outstanding_o), 0);
    chk("t7_rst_valid", 32'(mst_rsp_valid_o), 0);
    chk("t7_rst_rsp_ready", 32'(slv_rsp_ready_o), 0);
    slv_rsp_valid_i = 1'b0; slv_req_ready_i = 1'b0;
    #1;
    chk("t7_rst_req_ready", 32'(req_ready_o), 0);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    chk("t7_post_rst_count", 32'(outstanding_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
